// File: rtl/bist_ctrl.sv
// Built-in self-test sequencer: resets the CUT and MISR, drives NVEC LFSR patterns,
// drains the pipeline, then compares the MISR signature against GOLDEN.
module bist_ctrl #(
    parameter int               NBIT      = 6,
    parameter int               NVEC      = 64,
    parameter int               PIPE      = 2,
    parameter logic [7:0]       LFSR_SEED = 8'hA5,
    parameter logic [NBIT-1:0]  GOLDEN    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NBIT-1:0] signature,
    output logic            test_mode,
    output logic [3:0]      pattern,
    output logic            cut_rst,
    output logic            misr_rst,
    output logic            busy,
    output logic            done,
    output logic            pass
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [15:0] RUN_LAST    = 16'(NVEC - 1);
    localparam logic [15:0] SETTLE_LAST = 16'((PIPE > 0) ? (PIPE - 1) : 0);
    localparam logic [2:0]  AFTER_RUN   = (PIPE > 0) ? S_SETTLE : S_COMPARE;

    logic [2:0]  state;
    logic [7:0]  lfsr;
    logic [15:0] cnt;

    // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            lfsr  <= LFSR_SEED;
            cnt   <= '0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_INIT;
                end
                S_INIT: begin
                    lfsr  <= LFSR_SEED;
                    cnt   <= '0;
                    pass  <= 1'b0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    lfsr <= lfsr_next(lfsr);
                    if (cnt == RUN_LAST) begin
                        cnt   <= '0;
                        state <= AFTER_RUN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_COMPARE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_COMPARE: begin
                    pass  <= (signature == GOLDEN);
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // A held start parks here; no automatic rerun.
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Decoded outputs are forced low for the whole cycle in which rst is asserted.
    always_comb begin
        test_mode = 1'b0;
        pattern   = 4'b0000;
        cut_rst   = 1'b0;
        misr_rst  = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            case (state)
                S_INIT: begin
                    cut_rst  = 1'b1;
                    misr_rst = 1'b1;
                    busy     = 1'b1;
                end
                S_RUN: begin
                    test_mode = 1'b1;
                    pattern   = lfsr[3:0];
                    busy      = 1'b1;
                end
                S_SETTLE: begin
                    test_mode = 1'b1;
                    busy      = 1'b1;
                end
                S_COMPARE: begin
                    busy = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_ctrl.sv
// Randomized bench for bist_ctrl against a run-position reference model.
module tb_bist_ctrl;

    localparam int               NBIT      = 6;
    localparam int               NVEC      = 64;
    localparam int               PIPE      = 2;
    localparam logic [7:0]       LFSR_SEED = 8'hA5;
    localparam logic [NBIT-1:0]  GOLDEN    = 6'h2B;

    logic            clk;
    logic            rst;
    logic            start;
    logic [NBIT-1:0] signature;
    logic            test_mode;
    logic [3:0]      pattern;
    logic            cut_rst;
    logic            misr_rst;
    logic            busy;
    logic            done;
    logic            pass;

    bist_ctrl #(
        .NBIT(NBIT), .NVEC(NVEC), .PIPE(PIPE), .LFSR_SEED(LFSR_SEED), .GOLDEN(GOLDEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .signature(signature),
        .test_mode(test_mode), .pattern(pattern), .cut_rst(cut_rst),
        .misr_rst(misr_rst), .busy(busy), .done(done), .pass(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: -1 idle, -2 done, 0 init, 1..NVEC run vector index, then drain, then compare.
    int         m_pos   = -1;
    logic       m_done  = 1'b0;
    logic       m_pass  = 1'b0;
    bit         m_known = 1'b0;
    logic [3:0] pat_tab [NVEC];
    logic [3:0] first3  [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [NBIT-1:0] sg);
        logic [3:0] ep;
        @(negedge clk);
        rst       = r;
        start     = s;
        signature = sg;
        #1;
        ep = (!r && m_pos >= 1 && m_pos <= NVEC) ? pat_tab[m_pos-1] : 4'h0;
        chk("busy",      32'(busy),      32'(!r && m_pos >= 0));
        chk("test_mode", 32'(test_mode), 32'(!r && m_pos >= 1 && m_pos <= NVEC + PIPE));
        chk("pattern",   32'(pattern),   32'(ep));
        chk("cut_rst",   32'(cut_rst),   32'(!r && m_pos == 0));
        chk("misr_rst",  32'(misr_rst),  32'(!r && m_pos == 0));
        if (!r && m_pos >= 1 && m_pos <= 3)
            chk("first_pat", 32'(pattern), 32'(first3[m_pos-1]));
        if (m_known) begin
            chk("done", 32'(done), 32'(m_done));
            chk("pass", 32'(pass), 32'(m_pass));
        end
        @(posedge clk);
        if (r) begin
            m_pos = -1; m_done = 1'b0; m_pass = 1'b0; m_known = 1'b1;
        end else if (m_pos == -1) begin
            if (s) m_pos = 0;
        end else if (m_pos == -2) begin
            if (!s) begin m_pos = -1; m_done = 1'b0; end
        end else if (m_pos == 0) begin
            m_pass = 1'b0; m_pos = 1;
        end else if (m_pos <= NVEC + PIPE) begin
            m_pos++;
        end else begin
            m_pass = (sg == GOLDEN); m_done = 1'b1; m_pos = -2;
        end
    endtask

    // mode 0: golden signature, 1: golden^1, 2: random signature, 3: reset at RUN cycle 10
    task automatic do_run(input int mode);
        int              edges;
        logic            r;
        logic            s;
        logic [NBIT-1:0] sg;
        bit              aborted;
        edges   = 0;
        aborted = 1'b0;
        step(1'b0, 1'b1, NBIT'($urandom));
        while (edges < 200) begin
            s  = 1'($urandom_range(0, 1));
            sg = NBIT'($urandom);
            if (m_pos == NVEC + PIPE + 1) begin
                if (mode == 0) sg = GOLDEN;
                else if (mode == 1) sg = GOLDEN ^ 6'h01;
            end
            r = (mode == 3 && m_pos == 10);
            step(r, s, sg);
            if (r) begin
                aborted = 1'b1;
                break;
            end
            edges++;
            #1;
            if (done === 1'b1) break;
        end
        if (!aborted) begin
            chk("latency", 32'(edges), 32'(NVEC + PIPE + 2));
            if (mode == 0) chk("pass_golden", 32'(pass), 32'd1);
            if (mode == 1) chk("pass_bad",    32'(pass), 32'd0);
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b1, NBIT'($urandom));
            step(1'b0, 1'b0, NBIT'($urandom));
        end
        repeat (2) step(1'b0, 1'b0, NBIT'($urandom));
    endtask

    initial begin
        logic [7:0] v;
        first3[0] = 4'h5;
        first3[1] = 4'hA;
        first3[2] = 4'h5;
        v = LFSR_SEED;
        for (int i = 0; i < NVEC; i++) begin
            pat_tab[i] = v[3:0];
            v = {v[6:0], ^(v & 8'hB8)};
        end

        rst       = 1'b1;
        start     = 1'b0;
        signature = '0;
        step(1'b1, 1'b1, NBIT'($urandom));
        step(1'b1, 1'b1, NBIT'($urandom));
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_test_mode", 32'(test_mode), 32'd0);
        chk("rst_pattern",   32'(pattern),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_pass",      32'(pass),      32'd0);
        repeat (2) step(1'b0, 1'b0, NBIT'($urandom));

        do_run(0);
        do_run(1);
        do_run(3);
        do_run(0);
        step(1'b1, 1'b1, NBIT'($urandom));
        step(1'b0, 1'b0, NBIT'($urandom));
        for (int k = 0; k < 4; k++) do_run(int'($urandom_range(0, 2)));
        do_run(3);
        do_run(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
